// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shifter datapath and its multi-cycle sequencer.
// Holds the machine word, shifter operation and sequencer state enums.
package package_shifter;

   typedef logic [15:0] MICRO1_MACHINE_WORD;

   typedef enum logic [2:0] {
      NOP,
      LEFT_LOGICALLY,
      RIGHT_LOGICALLY,
      LEFT_ARITHMETICALLY,
      RIGHT_ARITHMETICALLY,
      EXTENSION,
      SWAP
   } SHIFTER_OPERATION;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } SHIFT_SEQUENCER_STATE;

   // Only the shift operations honour the step count; the rest run exactly once.
   function automatic logic is_multi_step(input SHIFTER_OPERATION op);
      return op inside {LEFT_LOGICALLY, RIGHT_LOGICALLY,
                        LEFT_ARITHMETICALLY, RIGHT_ARITHMETICALLY};
   endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step shifter: one bit position per evaluation, purely combinational.
// Zero latency; no flow control.
module shifter
   import package_shifter::*;
(
   input  SHIFTER_OPERATION   operation,
   input  MICRO1_MACHINE_WORD in,
   input  logic               cin,
   output MICRO1_MACHINE_WORD out,
   output logic               cout
);

   always_comb begin
      out  = in;
      cout = 1'b0;
      case (operation)
         LEFT_LOGICALLY, LEFT_ARITHMETICALLY: begin
            out  = {in[14:0], cin};
            cout = in[15];
         end
         RIGHT_LOGICALLY: begin
            out  = {cin, in[15:1]};
            cout = in[0];
         end
         RIGHT_ARITHMETICALLY: begin
            out  = {in[15], in[15:1]};
            cout = in[0];
         end
         EXTENSION: out = {{8{in[7]}}, in[7:0]};
         SWAP:      out = {in[7:0], in[15:8]};
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Iterates the single-step shifter 0..2^AMOUNT_WIDTH-1 times; latency N+1 edges to done, start ignored while busy.
// SHIFT_SEQUENCER_CARRY_CHAIN_EN: feed each step's carry-out into the next step's carry-in.
module shift_sequencer
   import package_shifter::*;
#(
   parameter int AMOUNT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  SHIFTER_OPERATION        operation,
   input  logic [AMOUNT_WIDTH-1:0] amount,
   input  MICRO1_MACHINE_WORD      in,
   input  logic                    cin,
   output logic                    busy,
   output logic                    done,
   output MICRO1_MACHINE_WORD      out,
   output logic                    cout
);

   SHIFT_SEQUENCER_STATE    state;
   SHIFTER_OPERATION        op_l;
   logic [AMOUNT_WIDTH-1:0] count;
   logic [AMOUNT_WIDTH-1:0] load;
   MICRO1_MACHINE_WORD      work;
   logic                    carry;
   logic                    step_cin;
   MICRO1_MACHINE_WORD      sh_out;
   logic                    sh_cout;

`ifdef SHIFT_SEQUENCER_CARRY_CHAIN_EN
   // carry holds the latched cin until the first step, then each step's carry-out.
   assign step_cin = carry;
`else
   logic cin_l;
   assign step_cin = cin_l;
`endif

   always_comb begin
      load = is_multi_step(operation) ? amount : AMOUNT_WIDTH'(1);
   end

   shifter u_shifter (
      .operation (op_l),
      .in        (work),
      .cin       (step_cin),
      .out       (sh_out),
      .cout      (sh_cout)
   );

   assign out  = work;
   assign cout = carry;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_l  <= NOP;
         count <= '0;
         work  <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifndef SHIFT_SEQUENCER_CARRY_CHAIN_EN
         cin_l <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_l  <= operation;
                  work  <= in;
                  count <= load;
                  busy  <= 1'b1;
`ifndef SHIFT_SEQUENCER_CARRY_CHAIN_EN
                  cin_l <= cin;
`endif
                  if (load == '0) begin
                     carry <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     carry <= cin;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               work  <= sh_out;
               carry <= sh_cout;
               count <= count - AMOUNT_WIDTH'(1);
               if (count == AMOUNT_WIDTH'(1)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
